// File: rtl/debug_pkg.sv
// ============================================================================
// Module  : debug_pkg
// Purpose : Shared abstract-access FSM state encoding and access error codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package debug_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NOTHALT = 2'd1;
    localparam logic [1:0] ERR_TMO     = 2'd2;
    localparam logic [1:0] ERR_EXC     = 2'd3;

endpackage

`default_nettype wire

// File: rtl/debug_hart_ctrl_if.sv
// ============================================================================
// Module  : debug_hart_ctrl_if
// Purpose : Abstract-access handshake and core register port bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface debug_hart_ctrl_if #(
    parameter int NHART = 2,
    parameter int DW    = 64,
    parameter int AW    = 16
);
    logic                acc_valid;
    logic                acc_ready;
    logic                acc_wen;
    logic [AW-1:0]       acc_addr;
    logic [DW-1:0]       acc_arg;
    logic [DW-1:0]       acc_res;
    logic                acc_done;
    logic [1:0]          acc_err;

    logic [NHART-1:0]    reg_req;
    logic                reg_wen;
    logic [AW-1:0]       reg_addr;
    logic [DW-1:0]       reg_wdata;
    logic [NHART-1:0]    reg_ack;
    logic [NHART-1:0]    reg_exc;
    logic [NHART*DW-1:0] reg_rdata;

    // master: debug module side issuing commands and modelling the cores
    modport master (
        output acc_valid, acc_wen, acc_addr, acc_arg,
        input  acc_ready, acc_res, acc_done, acc_err,
        input  reg_req, reg_wen, reg_addr, reg_wdata,
        output reg_ack, reg_exc, reg_rdata
    );

    modport slave (
        input  acc_valid, acc_wen, acc_addr, acc_arg,
        output acc_ready, acc_res, acc_done, acc_err,
        output reg_req, reg_wen, reg_addr, reg_wdata,
        input  reg_ack, reg_exc, reg_rdata
    );
endinterface

`default_nettype wire

// File: rtl/debug_hart_slot.sv
// ============================================================================
// Module  : debug_hart_slot
// Purpose : Per-hart halt, resume and reset request/status tracking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_hart_slot (
    input  wire  CLK,
    input  wire  RSTn,
    input  wire  sel,
    input  wire  dm_haltreq,
    input  wire  dm_resumereq,
    input  wire  dm_hartreset,
    input  wire  dm_ackhavereset,
    input  wire  hart_halted,
    output logic halted,
    output logic running,
    output logic resumeack,
    output logic havereset,
    output logic hartHaltreq,
    output logic hartResumereq,
    output logic hartReset
);

    logic w_haltHere;
    logic w_resetHere;

    assign w_haltHere  = dm_haltreq & sel;
    assign w_resetHere = dm_hartreset & sel;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            halted        <= 1'b0;
            running       <= 1'b0;
            resumeack     <= 1'b0;
            havereset     <= 1'b1;
            hartHaltreq   <= 1'b0;
            hartResumereq <= 1'b0;
            hartReset     <= 1'b0;
        end else begin
            hartHaltreq <= w_haltHere;
            halted      <= hart_halted;
            running     <= ~hart_halted;
            hartReset   <= w_resetHere;

            // a concurrent halt request swallows the resume
            if (dm_resumereq & sel & ~w_haltHere & halted) begin
                hartResumereq <= 1'b1;
                resumeack     <= 1'b0;
            end else if (hartResumereq & ~hart_halted) begin
                hartResumereq <= 1'b0;
                resumeack     <= 1'b1;
            end

            if (hartReset & ~w_resetHere) begin
                havereset <= 1'b1;
            end else if (dm_ackhavereset & sel) begin
                havereset <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/debug_hart_ctrl.sv
// ============================================================================
// Module  : debug_hart_ctrl
// Purpose : Multi-hart run control plus abstract register access sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_hart_ctrl
    import debug_pkg::*;
#(
    parameter int NHART = 2,
    parameter int DW    = 64,
    parameter int AW    = 16,
    parameter int TMO   = 255,
    localparam int c_SW = (NHART > 1) ? $clog2(NHART) : 1
) (
    input  wire              CLK,
    input  wire              RSTn,
    input  wire  [c_SW-1:0]  dm_hartsel,
    input  wire              dm_haltreq,
    input  wire              dm_resumereq,
    input  wire              dm_hartreset,
    input  wire              dm_ackhavereset,
    output logic [NHART-1:0] dm_halted,
    output logic [NHART-1:0] dm_running,
    output logic [NHART-1:0] dm_resumeack,
    output logic [NHART-1:0] dm_havereset,
    output logic [NHART-1:0] hart_haltreq,
    output logic [NHART-1:0] hart_resumereq,
    output logic [NHART-1:0] hart_reset,
    input  wire  [NHART-1:0] hart_halted,
    debug_hart_ctrl_if.slave bus
);

    localparam logic [7:0]       c_TMO = 8'(TMO);
    localparam logic [NHART-1:0] c_ONE = NHART'(1);

    for (genvar gi = 0; gi < NHART; gi++) begin : g_slot
        debug_hart_slot u_slot (
            .CLK             (CLK),
            .RSTn            (RSTn),
            .sel             (dm_hartsel == c_SW'(gi)),
            .dm_haltreq      (dm_haltreq),
            .dm_resumereq    (dm_resumereq),
            .dm_hartreset    (dm_hartreset),
            .dm_ackhavereset (dm_ackhavereset),
            .hart_halted     (hart_halted[gi]),
            .halted          (dm_halted[gi]),
            .running         (dm_running[gi]),
            .resumeack       (dm_resumeack[gi]),
            .havereset       (dm_havereset[gi]),
            .hartHaltreq     (hart_haltreq[gi]),
            .hartResumereq   (hart_resumereq[gi]),
            .hartReset       (hart_reset[gi])
        );
    end

    logic [1:0]       r_state;
    logic [c_SW-1:0]  r_sel;
    logic             r_wen;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_arg;
    logic             r_notHalted;
    logic [7:0]       r_cnt;
    logic [NHART-1:0] r_regReq;
    logic             r_accDone;
    logic [1:0]       r_accErr;
    logic [DW-1:0]    r_accRes;

    logic             w_ack;
    logic             w_exc;
    logic [DW-1:0]    w_rdata;

    assign w_ack   = bus.reg_ack[r_sel];
    assign w_exc   = bus.reg_exc[r_sel];
    assign w_rdata = bus.reg_rdata[int'(r_sel)*DW +: DW];

    // A command to a running hart still spends one cycle in REQ with the core
    // port gated, so every outcome shares the same minimum latency.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= c_ST_IDLE;
            r_sel       <= '0;
            r_wen       <= 1'b0;
            r_addr      <= '0;
            r_arg       <= '0;
            r_notHalted <= 1'b0;
            r_cnt       <= 8'd0;
            r_regReq    <= '0;
            r_accDone   <= 1'b0;
            r_accErr    <= ERR_NONE;
            r_accRes    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_accDone <= 1'b0;
                    if (bus.acc_valid) begin
                        r_sel       <= dm_hartsel;
                        r_wen       <= bus.acc_wen;
                        r_addr      <= bus.acc_addr;
                        r_arg       <= bus.acc_arg;
                        r_cnt       <= 8'd0;
                        r_notHalted <= ~dm_halted[dm_hartsel];
                        r_regReq    <= dm_halted[dm_hartsel] ? (c_ONE << dm_hartsel) : '0;
                        r_state     <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_notHalted || w_ack || hart_reset[r_sel] || (r_cnt == c_TMO)) begin
                        r_state   <= c_ST_DONE;
                        r_regReq  <= '0;
                        r_accDone <= 1'b1;
                    end
                    if (r_notHalted) begin
                        r_accErr <= ERR_NOTHALT;
                    end else if (w_ack && w_exc) begin
                        r_accErr <= ERR_EXC;
                    end else if (w_ack) begin
                        r_accErr <= ERR_NONE;
                        r_accRes <= w_rdata;
                    end else if (hart_reset[r_sel]) begin
                        r_accErr <= ERR_NOTHALT;
                    end else if (r_cnt == c_TMO) begin
                        r_accErr <= ERR_TMO;
                    end
                end
                c_ST_DONE: begin
                    r_accDone <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
                default: begin
                    r_accDone <= 1'b0;
                    r_regReq  <= '0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.acc_ready = (r_state == c_ST_IDLE);
    assign bus.acc_done  = r_accDone;
    assign bus.acc_err   = r_accErr;
    assign bus.acc_res   = r_accRes;
    assign bus.reg_req   = r_regReq;
    assign bus.reg_wen   = r_wen;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_wdata = r_arg;

endmodule

`default_nettype wire

// File: tb/tb_debug_hart_ctrl.sv
// ============================================================================
// Module  : tb_debug_hart_ctrl
// Purpose : Directed and randomized self-checking bench for debug_hart_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_hart_ctrl;

    localparam int NHART = 2;
    localparam int DW    = 64;
    localparam int AW    = 16;
    localparam int TMO   = 4;

    logic             CLK;
    logic             RSTn;
    logic [0:0]       dm_hartsel;
    logic             dm_haltreq;
    logic             dm_resumereq;
    logic             dm_hartreset;
    logic             dm_ackhavereset;
    logic [NHART-1:0] dm_halted;
    logic [NHART-1:0] dm_running;
    logic [NHART-1:0] dm_resumeack;
    logic [NHART-1:0] dm_havereset;
    logic [NHART-1:0] hart_haltreq;
    logic [NHART-1:0] hart_resumereq;
    logic [NHART-1:0] hart_reset;
    logic [NHART-1:0] hart_halted;

    int               nTests;
    int               nFail;
    logic [63:0]      lastRes;

    debug_hart_ctrl_if #(.NHART(NHART), .DW(DW), .AW(AW)) bus ();

    debug_hart_ctrl #(.NHART(NHART), .DW(DW), .AW(AW), .TMO(TMO)) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .dm_hartsel      (dm_hartsel),
        .dm_haltreq      (dm_haltreq),
        .dm_resumereq    (dm_resumereq),
        .dm_hartreset    (dm_hartreset),
        .dm_ackhavereset (dm_ackhavereset),
        .dm_halted       (dm_halted),
        .dm_running      (dm_running),
        .dm_resumeack    (dm_resumeack),
        .dm_havereset    (dm_havereset),
        .hart_haltreq    (hart_haltreq),
        .hart_resumereq  (hart_resumereq),
        .hart_reset      (hart_reset),
        .hart_halted     (hart_halted),
        .bus             (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Outcome of an access from the rules: the earliest event wins, ties go
    // to ack before hart reset before timeout. k counts REQ cycles from 1.
    function automatic void model(input bit halted, input int ackAt, input bit exc,
                                  input int rstAt, output int lat, output logic [1:0] err);
        int tAck;
        int tRst;
        int tTmo;
        if (!halted) begin
            lat = 2;
            err = 2'd1;
            return;
        end
        tTmo = TMO + 1;
        tAck = (ackAt >= 1) ? ackAt : 1000;
        tRst = (rstAt >= 1) ? rstAt + 1 : 1000;
        if (tAck <= tRst && tAck <= tTmo) begin
            lat = tAck + 1;
            err = exc ? 2'd3 : 2'd0;
        end else if (tRst <= tTmo) begin
            lat = tRst + 1;
            err = 2'd1;
        end else begin
            lat = tTmo + 1;
            err = 2'd2;
        end
    endfunction

    task automatic run_access(input string tag, input int hart, input bit wen,
                              input logic [15:0] addr, input logic [63:0] arg,
                              input int ackAt, input bit exc, input logic [63:0] data,
                              input int rstAt);
        int          expLat;
        logic [1:0]  expErr;
        logic [63:0] expRes;
        logic [1:0]  expReq;
        bit          halted;
        bit          seen;
        int          c;
        halted = hart_halted[hart];
        model(halted, ackAt, exc, rstAt, expLat, expErr);
        expRes = (halted && expErr == 2'd0) ? data : lastRes;
        expReq = halted ? 2'(1 << hart) : 2'b00;

        check({tag, "_ready"}, 64'(bus.acc_ready), 64'(1));
        dm_hartsel    = 1'(hart);
        bus.acc_valid = 1'b1;
        bus.acc_wen   = wen;
        bus.acc_addr  = addr;
        bus.acc_arg   = arg;
        step();
        bus.acc_valid = 1'b0;
        dm_hartsel    = 1'(1 - hart);
        seen = 1'b0;
        c    = 1;
        while (c <= TMO + 6) begin
            if (bus.acc_done) begin
                seen = 1'b1;
                break;
            end
            check({tag, "_regreq"}, 64'(bus.reg_req), 64'(expReq));
            if (halted && c == 1) begin
                check({tag, "_regaddr"}, 64'(bus.reg_addr), 64'(addr));
                check({tag, "_regwen"}, 64'(bus.reg_wen), 64'(wen));
                check({tag, "_regwdata"}, bus.reg_wdata, arg);
            end
            bus.reg_ack   = '0;
            bus.reg_exc   = '0;
            dm_hartreset  = 1'b0;
            if (c == ackAt) begin
                bus.reg_rdata = {$urandom, $urandom, $urandom, $urandom};
                bus.reg_rdata[hart*64 +: 64] = data;
                bus.reg_ack[hart] = 1'b1;
                bus.reg_exc[hart] = exc;
            end
            if (rstAt > 0 && c == rstAt) begin
                dm_hartsel   = 1'(hart);
                dm_hartreset = 1'b1;
            end
            step();
            c++;
        end
        bus.reg_ack  = '0;
        bus.reg_exc  = '0;
        dm_hartreset = 1'b0;
        check({tag, "_doneseen"}, 64'(seen), 64'(1));
        check({tag, "_latency"}, 64'(c), 64'(expLat));
        check({tag, "_err"}, 64'(bus.acc_err), 64'(expErr));
        check({tag, "_res"}, bus.acc_res, expRes);
        step();
        check({tag, "_donepulse"}, 64'(bus.acc_done), 64'(0));
        check({tag, "_idle"}, 64'(bus.acc_ready), 64'(1));
        check({tag, "_errhold"}, 64'(bus.acc_err), 64'(expErr));
        lastRes = expRes;
    endtask

    initial begin
        nTests          = 0;
        nFail           = 0;
        lastRes         = '0;
        RSTn            = 1'b0;
        dm_hartsel      = '0;
        dm_haltreq      = 1'b0;
        dm_resumereq    = 1'b0;
        dm_hartreset    = 1'b0;
        dm_ackhavereset = 1'b0;
        hart_halted     = '0;
        bus.acc_valid   = 1'b0;
        bus.acc_wen     = 1'b0;
        bus.acc_addr    = '0;
        bus.acc_arg     = '0;
        bus.reg_ack     = '0;
        bus.reg_exc     = '0;
        bus.reg_rdata   = '0;

        step();
        step();
        check("rst_halted", 64'(dm_halted), 64'(0));
        check("rst_running", 64'(dm_running), 64'(0));
        check("rst_havereset", 64'(dm_havereset), 64'(2'b11));
        check("rst_haltreq", 64'(hart_haltreq), 64'(0));
        check("rst_done", 64'(bus.acc_done), 64'(0));
        check("rst_regreq", 64'(bus.reg_req), 64'(0));
        RSTn = 1'b1;
        step();
        check("post_rst_running", 64'(dm_running), 64'(2'b11));
        check("post_rst_ready", 64'(bus.acc_ready), 64'(1));

        // halt request to hart 1
        dm_hartsel = 1'b1;
        dm_haltreq = 1'b1;
        step();
        check("haltreq_h1", 64'(hart_haltreq), 64'(2'b10));
        dm_haltreq     = 1'b0;
        hart_halted[1] = 1'b1;
        step();
        check("halted_h1", 64'(dm_halted), 64'(2'b10));
        check("running_h1", 64'(dm_running), 64'(2'b01));
        check("haltreq_drop", 64'(hart_haltreq), 64'(0));

        // resume hart 0
        hart_halted[0] = 1'b1;
        step();
        step();
        dm_hartsel   = 1'b0;
        dm_resumereq = 1'b1;
        step();
        dm_resumereq = 1'b0;
        check("resreq_set", 64'(hart_resumereq), 64'(2'b01));
        check("resack_clr", 64'(dm_resumeack), 64'(0));
        step();
        step();
        check("resreq_hold", 64'(hart_resumereq), 64'(2'b01));
        hart_halted[0] = 1'b0;
        step();
        check("resreq_done", 64'(hart_resumereq), 64'(0));
        check("resack_set", 64'(dm_resumeack), 64'(2'b01));

        // second resume clears the sticky ack
        hart_halted[0] = 1'b1;
        step();
        step();
        dm_resumereq = 1'b1;
        step();
        dm_resumereq = 1'b0;
        check("resack_reclr", 64'(dm_resumeack), 64'(0));
        hart_halted[0] = 1'b0;
        step();
        check("resack_reset2", 64'(dm_resumeack), 64'(2'b01));

        // resume to a running hart is ignored
        dm_resumereq = 1'b1;
        step();
        dm_resumereq = 1'b0;
        check("resreq_ignored", 64'(hart_resumereq), 64'(0));
        check("resack_kept", 64'(dm_resumeack), 64'(2'b01));

        // halt and resume together: halt wins
        hart_halted[0] = 1'b1;
        step();
        step();
        dm_haltreq   = 1'b1;
        dm_resumereq = 1'b1;
        step();
        dm_haltreq   = 1'b0;
        dm_resumereq = 1'b0;
        check("halt_wins_res", 64'(hart_resumereq), 64'(0));
        check("halt_wins_halt", 64'(hart_haltreq), 64'(2'b01));

        // hart reset and havereset
        dm_hartsel      = 1'b1;
        dm_ackhavereset = 1'b1;
        step();
        dm_ackhavereset = 1'b0;
        check("havereset_ack", 64'(dm_havereset), 64'(2'b01));
        dm_hartreset = 1'b1;
        step();
        check("hartreset_set", 64'(hart_reset), 64'(2'b10));
        check("havereset_wait", 64'(dm_havereset), 64'(2'b01));
        dm_hartreset    = 1'b0;
        dm_ackhavereset = 1'b1;
        step();
        dm_ackhavereset = 1'b0;
        check("hartreset_fall", 64'(hart_reset), 64'(0));
        check("havereset_setwins", 64'(dm_havereset), 64'(2'b11));
        dm_ackhavereset = 1'b1;
        step();
        dm_ackhavereset = 1'b0;
        check("havereset_ack2", 64'(dm_havereset), 64'(2'b01));

        // abstract accesses
        hart_halted[1] = 1'b0;
        step();
        step();
        run_access("nothalt", 1, 1'b0, 16'h0042, 64'h1234, 1, 1'b0, 64'h5555, 0);
        run_access("read", 0, 1'b0, 16'h1001, 64'h0, 3, 1'b0, 64'hDEADBEEF, 0);
        run_access("timeout", 0, 1'b1, 16'h2002, 64'hCAFE_F00D_0000_0001, 0, 1'b0, 64'h0, 0);
        run_access("except", 0, 1'b1, 16'h0300, 64'h77, 1, 1'b1, 64'hABCD, 0);
        run_access("hartrst", 0, 1'b0, 16'h0400, 64'h0, 0, 1'b0, 64'h0, 2);

        for (int i = 0; i < 12; i++) begin
            hart_halted = 2'($urandom_range(0, 3));
            step();
            step();
            run_access("rand", int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       16'($urandom), {$urandom, $urandom},
                       int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                       {$urandom, $urandom}, 0);
        end

        // reset with an access in flight
        begin
            bit doneSeen;
            hart_halted = 2'b01;
            step();
            step();
            dm_hartsel    = 1'b0;
            bus.acc_valid = 1'b1;
            step();
            bus.acc_valid = 1'b0;
            step();
            RSTn = 1'b0;
            #1;
            check("flight_regreq", 64'(bus.reg_req), 64'(0));
            check("flight_havereset", 64'(dm_havereset), 64'(2'b11));
            step();
            RSTn = 1'b1;
            doneSeen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (bus.acc_done) doneSeen = 1'b1;
            end
            check("flight_nodone", 64'(doneSeen), 64'(0));
            check("flight_ready", 64'(bus.acc_ready), 64'(1));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debug_hart_ctrl.md
DEBUG_HART_CTRL -- requirements
Module: debug_hart_ctrl

Interface
REQ-001 Parameter NHART, default 2: number of harts monitored; legal range 2..16.
REQ-002 Parameter DW, default 64: abstract register data width.
REQ-003 Parameter AW, default 16: abstract register address width.
REQ-004 Parameter TMO, default 255: abstract-access timeout, in cycles.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 Ports (name direction width meaning):
- CLK  in  1  clock.
- RSTn  in  1  asynchronous active-low reset.
- dm_hartsel  in  $clog2(NHART)  selected hart.
- dm_haltreq  in  1  level halt request for the selected hart.
- dm_resumereq  in  1  pulse resume request.
- dm_hartreset  in  1  level reset request for the selected hart.
- dm_ackhavereset  in  1  pulse that clears havereset of the selected hart.
- dm_halted  out  NHART  per-hart halted status.
- dm_running  out  NHART  per-hart running status.
- dm_resumeack  out  NHART  sticky resume acknowledge.
- dm_havereset  out  NHART  sticky reset-seen flag.
- hart_haltreq, hart_resumereq, hart_reset  out  NHART each  requests to the cores.
- hart_halted  in  NHART  core halted status.
- acc_valid  in  1, acc_ready  out  1  access handshake.
- acc_wen  in  1, acc_addr  in  AW, acc_arg  in  DW  access command.
- acc_res  out  DW, acc_done  out  1, acc_err  out  2  access result.
- reg_req  out  NHART, reg_wen  out  1, reg_addr  out  AW, reg_wdata  out  DW  core register port.
- reg_ack  in  NHART, reg_exc  in  NHART, reg_rdata  in  NHART*DW (hart i at slice i)  core register response.

Function
REQ-007 hart_haltreq[i] SHALL be registered (dm_haltreq & dm_hartsel==i), giving 1-cycle latency.
REQ-008 dm_halted SHALL be hart_halted registered once; dm_running SHALL be ~dm_halted.
REQ-009 Resume flow:
- dm_resumereq to a halted hart SHALL set hart_resumereq[sel] and clear dm_resumeack[sel].
- hart_resumereq[sel] SHALL hold until hart_halted[sel] falls; it then clears and dm_resumeack[sel] sets.
- dm_resumereq to a non-halted hart SHALL be ignored.
REQ-010 dm_haltreq and dm_resumereq in the same cycle: the halt SHALL win and the resume SHALL be dropped.
REQ-011 Hart reset flow:
- hart_reset[i] SHALL be registered (dm_hartreset & sel==i).
- On hart_reset[i] falling, dm_havereset[i] SHALL set.
- dm_ackhavereset SHALL clear dm_havereset[sel].
- If set and clear coincide, set SHALL win.
REQ-012 Abstract-access FSM states IDLE, REQ, DONE; acc_ready SHALL be 1 only in IDLE.
REQ-013 On acc_valid & acc_ready, the FSM SHALL capture dm_hartsel, acc_wen, acc_addr and acc_arg; later hartsel changes SHALL NOT affect the command.
REQ-014 If the captured hart is not halted at accept, the FSM SHALL go to DONE with acc_err=1 and SHALL NOT assert reg_req.
REQ-015 In REQ:
- reg_req[sel] SHALL be 1 and the captured fields SHALL drive reg_wen, reg_addr and reg_wdata.
- An 8-bit counter SHALL increment each cycle.
REQ-016 REQ exits to DONE on the first event below, listed in priority order:
- reg_ack[sel] & reg_exc[sel]: acc_err=3.
- reg_ack[sel]: acc_err=0; acc_res = rdata slice (writes also return the slice).
- hart_reset[sel] asserted: acc_err=1.
- counter == TMO: acc_err=2.
REQ-017 DONE SHALL last exactly 1 cycle with acc_done=1, then return to IDLE.
REQ-018 acc_res and acc_err SHALL hold until the next DONE.
REQ-019 Accept-to-done latency SHALL be 2 cycles minimum and TMO+2 cycles maximum.

Reset
REQ-020 RSTn low SHALL clear all registers: FSM to IDLE, counter 0, all outputs 0 (dm_running therefore reads all-ones one cycle after release, per REQ-008).
REQ-021 dm_havereset SHALL reset to all-ones.
REQ-022 An access in flight at reset SHALL be discarded without acc_done.

Structure
REQ-023 A shared package debug_pkg SHALL hold the FSM state encoding and the acc_err codes: ERR_NONE=0, ERR_NOTHALT=1, ERR_TMO=2, ERR_EXC=3.
REQ-024 Per-hart halt/resume/reset logic SHALL be a sub-module debug_hart_slot, instantiated NHART times by generate.

Verification
REQ-025 Bench scenarios:
- sel=1, haltreq=1 -> hart_haltreq=2'b10 next cycle; model raises hart_halted[1] -> dm_halted[1]=1 after 1 cycle.
- Hart 0 halted, resumereq pulse -> hart_resumereq[0]=1 until hart_halted[0] falls, then dm_resumeack[0]=1.
- Access to non-halted hart 1 -> acc_done 2 cycles after accept, acc_err=1, reg_req never asserted.
- Halted hart 0, read addr 0x1001, reg_ack returns 0xDEADBEEF after 3 cycles -> acc_res=0xDEADBEEF, acc_err=0.
- TMO=4, reg_ack never asserted -> acc_err=2, acc_done at cycle 6 after accept.
- hartreset pulse on hart 1 -> dm_havereset[1]=1; ackhavereset same cycle as a new set -> remains 1.
